// File: rtl/mips_cpu_pkg.sv
// Shared types and lane helpers for the MIPS core memory unit.
// Size encodings, FSM states and the byte-lane mapping used on the Avalon side.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } memSize_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUS   = 2'b01,
        RDATA = 2'b10,
        RESP  = 2'b11
    } memState_t;

    // Illegal size or an access that does not sit on its natural boundary.
    function automatic logic isBadReq(input memSize_t size, input logic [1:0] off);
        logic bad;
        bad = 1'b1;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            SIZE_ILL:  bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] laneEnable(input memSize_t size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating narrow stores means the lane picked by byteenable always carries the data.
    function automatic logic [31:0] laneData(input memSize_t size, input logic [31:0] wdata);
        logic [31:0] d;
        d = wdata;
        case (size)
            SIZE_BYTE: d = {4{wdata[7:0]}};
            SIZE_HALF: d = {2{wdata[15:0]}};
            default:   d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Load lane select and zero/sign extension (purely combinational).
// Lanes are little-endian: byte offset 0 is readdata[7:0].
module mips_cpu_load_align
    import mips_cpu_pkg::*;
(
    input  logic [31:0] readdata,
    input  logic [1:0]  byteOff,
    input  memSize_t    size,
    input  logic        signExt,
    output logic [31:0] loadData
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal  = readdata[{byteOff, 3'b000} +: 8];
        halfVal  = byteOff[1] ? readdata[31:16] : readdata[15:0];
        loadData = readdata;
        case (size)
            SIZE_BYTE: loadData = {{24{signExt & byteVal[7]}}, byteVal};
            SIZE_HALF: loadData = {{16{signExt & halfVal[15]}}, halfVal};
            default:   loadData = readdata;
        endcase
    end

endmodule

// File: rtl/mips_cpu_mem_unit.sv
// Core load/store unit bridging single requests onto an Avalon-MM master port.
// Define MIPS_MEM_TIMEOUT_EN to abort a bus access after WAIT_LIMIT waitrequest cycles.
module mips_cpu_mem_unit
    import mips_cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    memState_t   state, nextState;
    memSize_t    reqSize, sizeReg;
    logic        accept, badReq, timeoutHit;
    logic        writeReg, signedReg, errReg;
    logic [31:0] addrReg, wdataReg, rdataReg, loadData;
    logic [3:0]  beReg;

    assign reqSize = memSize_t'(req_size);
    assign accept  = req_valid && (state == IDLE);
    assign badReq  = isBadReq(reqSize, req_addr[1:0]);

`ifdef MIPS_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [CNT_W-1:0] stallCnt;

    // The cycle that would make the count reach WAIT_LIMIT is the last one spent on the bus.
    assign timeoutHit = (state == BUS) && waitrequest && (stallCnt == CNT_W'(WAIT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || state != BUS)
            stallCnt <= '0;
        else if (waitrequest)
            stallCnt <= stallCnt + 1'b1;
    end
`else
    // Without the timeout build the bus waits forever; this folds to constant 0.
    assign timeoutHit = (WAIT_LIMIT < 0);
`endif

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (accept) nextState = badReq ? RESP : BUS;
            BUS: begin
                if (!waitrequest)
                    nextState = writeReg ? RESP : RDATA;
                else if (timeoutHit)
                    nextState = RESP;
            end
            RDATA: nextState = RESP;
            RESP:  nextState = IDLE;
        endcase
    end

    mips_cpu_load_align uAlign (
        .readdata (readdata),
        .byteOff  (addrReg[1:0]),
        .size     (sizeReg),
        .signExt  (signedReg),
        .loadData (loadData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            writeReg  <= 1'b0;
            sizeReg   <= SIZE_BYTE;
            signedReg <= 1'b0;
            addrReg   <= '0;
            beReg     <= '0;
            wdataReg  <= '0;
            rdataReg  <= '0;
            errReg    <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                writeReg  <= req_write;
                sizeReg   <= reqSize;
                signedReg <= req_signed;
                addrReg   <= req_addr;
                beReg     <= badReq ? 4'b0000 : laneEnable(reqSize, req_addr[1:0]);
                wdataReg  <= laneData(reqSize, req_wdata);
                rdataReg  <= '0;
                errReg    <= badReq;
            end
            if (state == RDATA)
                rdataReg <= loadData;
            if (timeoutHit)
                errReg <= 1'b1;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_error = resp_valid && errReg;
    assign resp_rdata = rdataReg;
    assign read       = (state == BUS) && !writeReg;
    assign write      = (state == BUS) && writeReg;
    assign address    = {addrReg[31:2], 2'b00};
    assign byteenable = beReg;
    assign writedata  = wdataReg;

endmodule

// File: tb/tb_mips_cpu_mem_unit.sv
// Scoreboard bench for mips_cpu_mem_unit with a small Avalon slave model.
// Timeout scenario is built in only when MIPS_MEM_TIMEOUT_EN is defined.
module tb_mips_cpu_mem_unit;

`ifdef MIPS_MEM_TIMEOUT_EN
    localparam int WL = 4;
`else
    localparam int WL = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_error, read, write;
    logic [31:0] resp_rdata, address, writedata;
    logic [3:0]  byteenable;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'hDEADBEEF;

    mips_cpu_mem_unit #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sbQ[$];
    int errors = 0, checks = 0;
    int cyc = 0, acceptCyc = 0, accepts = 0, respCount = 0;
    int busHigh = 0, busIdx = 0, writeSeen = 0, stallsWanted = 0;
    bit stuck = 0, unstable = 0;
    logic [3:0]  busBe;
    logic [31:0] busWd, busAddr, rdataVal = '0;
    logic        readAcc = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready && !reset) begin
            acceptCyc <= cyc;
            accepts   <= accepts + 1;
        end
        readAcc <= read && !waitrequest;
    end

    // Avalon slave: waitrequest for stallsWanted cycles (or forever when stuck), fixed read latency 1.
    always @(negedge clk) begin
        if (read || write) begin
            if (busHigh == 0) begin
                busBe = byteenable; busWd = writedata; busAddr = address;
            end else if (byteenable !== busBe || writedata !== busWd || address !== busAddr) begin
                unstable = 1;
            end
            busHigh++;
            if (write) writeSeen++;
            waitrequest = stuck || (busIdx < stallsWanted);
            busIdx++;
        end else begin
            waitrequest = 1'b0;
            busIdx = 0;
        end
        readdata = readAcc ? rdataVal : 32'hDEADBEEF;
    end

    // Response monitor: every resp_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (resp_valid) begin
            exp_t e;
            respCount++;
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp rdata=%h err=%b", resp_rdata, resp_error);
            end else begin
                e = sbQ.pop_front();
                if (resp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL resp_rdata got=%h want=%h", resp_rdata, e.rdata);
                end
                checks++;
                if (resp_error !== e.err) begin
                    errors++;
                    $display("FAIL resp_error got=%b want=%b", resp_error, e.err);
                end
                checks++;
                if (cyc - acceptCyc != e.lat) begin
                    errors++;
                    $display("FAIL resp_latency got=%0d want=%0d", cyc - acceptCyc, e.lat);
                end
            end
        end
    end

    task automatic push(input logic [31:0] rd, input logic er, input int lat);
        exp_t e;
        e.rdata = rd; e.err = er; e.lat = lat;
        sbQ.push_back(e);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_issue got=%b want=1", req_ready);
        end
        busHigh = 0; unstable = 0; writeSeen = 0;
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic waitResp(input int target);
        int n = 0;
        while (respCount < target && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (respCount < target) begin
            errors++;
            $display("FAIL resp_wait got=%0d want=%0d", respCount, target);
            sbQ.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 9;
        if (req_ready !== 1'b1)     begin errors++; $display("FAIL rst_ready got=%b want=1", req_ready); end
        if (resp_valid !== 1'b0)    begin errors++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
        if (resp_error !== 1'b0)    begin errors++; $display("FAIL rst_resp_error got=%b want=0", resp_error); end
        if (resp_rdata !== 32'h0)   begin errors++; $display("FAIL rst_resp_rdata got=%h want=0", resp_rdata); end
        if (read !== 1'b0)          begin errors++; $display("FAIL rst_read got=%b want=0", read); end
        if (write !== 1'b0)         begin errors++; $display("FAIL rst_write got=%b want=0", write); end
        if (address !== 32'h0)      begin errors++; $display("FAIL rst_address got=%h want=0", address); end
        if (writedata !== 32'h0)    begin errors++; $display("FAIL rst_writedata got=%h want=0", writedata); end
        if (byteenable !== 4'h0)    begin errors++; $display("FAIL rst_byteenable got=%b want=0", byteenable); end
        reset = 1'b0;
    endtask

    task automatic test_loads();
        int base = respCount;
        // LB signed from the top lane
        stallsWanted = 0; rdataVal = 32'h80AABBCC;
        push(32'hFFFFFF80, 1'b0, 3);
        issue(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0);
        waitResp(base + 1);
        checks += 3;
        if (busBe !== 4'b1000)      begin errors++; $display("FAIL lb_be got=%b want=1000", busBe); end
        if (busAddr !== 32'h1000)   begin errors++; $display("FAIL lb_addr got=%h want=00001000", busAddr); end
        if (busHigh != 1)           begin errors++; $display("FAIL lb_read_cycles got=%0d want=1", busHigh); end
        // LBU from lane 1
        rdataVal = 32'h11223344;
        push(32'h00000033, 1'b0, 3);
        issue(1'b0, 2'b00, 1'b0, 32'h1001, 32'h0);
        waitResp(base + 2);
        // LH signed low half
        rdataVal = 32'h1234F00D;
        push(32'hFFFFF00D, 1'b0, 3);
        issue(1'b0, 2'b01, 1'b1, 32'h3000, 32'h0);
        waitResp(base + 3);
        checks++;
        if (busBe !== 4'b0011)      begin errors++; $display("FAIL lh_be got=%b want=0011", busBe); end
        // LW signed flag ignored
        rdataVal = 32'h89ABCDEF;
        push(32'h89ABCDEF, 1'b0, 3);
        issue(1'b0, 2'b10, 1'b1, 32'h4004, 32'h0);
        waitResp(base + 4);
    endtask

    task automatic test_stores();
        int base = respCount;
        // SH with three wait cycles
        stallsWanted = 3;
        push(32'h0, 1'b0, 5);
        issue(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000BEEF);
        waitResp(base + 1);
        checks += 5;
        if (busHigh != 4)            begin errors++; $display("FAIL sh_write_cycles got=%0d want=4", busHigh); end
        if (busBe !== 4'b1100)       begin errors++; $display("FAIL sh_be got=%b want=1100", busBe); end
        if (busWd !== 32'hBEEFBEEF)  begin errors++; $display("FAIL sh_wdata got=%h want=BEEFBEEF", busWd); end
        if (busAddr !== 32'h2000)    begin errors++; $display("FAIL sh_addr got=%h want=00002000", busAddr); end
        if (unstable)                begin errors++; $display("FAIL sh_stable got=1 want=0"); end
        // SB replicated
        stallsWanted = 0;
        push(32'h0, 1'b0, 2);
        issue(1'b1, 2'b00, 1'b0, 32'h5001, 32'h123456A5);
        waitResp(base + 2);
        checks += 2;
        if (busBe !== 4'b0010)       begin errors++; $display("FAIL sb_be got=%b want=0010", busBe); end
        if (busWd !== 32'hA5A5A5A5)  begin errors++; $display("FAIL sb_wdata got=%h want=A5A5A5A5", busWd); end
        // SW unchanged
        push(32'h0, 1'b0, 2);
        issue(1'b1, 2'b10, 1'b0, 32'h4000, 32'hCAFEF00D);
        waitResp(base + 3);
        checks += 2;
        if (busBe !== 4'b1111)       begin errors++; $display("FAIL sw_be got=%b want=1111", busBe); end
        if (busWd !== 32'hCAFEF00D)  begin errors++; $display("FAIL sw_wdata got=%h want=CAFEF00D", busWd); end
    endtask

    task automatic test_errors();
        int base = respCount;
        push(32'h0, 1'b1, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h1001, 32'h0);
        waitResp(base + 1);
        push(32'h0, 1'b1, 1);
        issue(1'b0, 2'b01, 1'b1, 32'h3001, 32'h0);
        waitResp(base + 2);
        push(32'h0, 1'b1, 1);
        issue(1'b1, 2'b11, 1'b0, 32'h1000, 32'hFFFFFFFF);
        waitResp(base + 3);
        checks++;
        if (busHigh != 0)            begin errors++; $display("FAIL err_bus_cycles got=%0d want=0", busHigh); end
    endtask

    task automatic test_ignore_busy();
        int base = respCount;
        int acc0 = accepts;
        // LHU with waits; a store offered mid-transfer must be ignored
        stallsWanted = 3; rdataVal = 32'h8001FFFF;
        push(32'h00008001, 1'b0, 6);
        issue(1'b0, 2'b01, 1'b0, 32'h3002, 32'h0);
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h8000; req_valid = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        waitResp(base + 1);
        checks += 2;
        if (accepts - acc0 != 1)     begin errors++; $display("FAIL busy_accepts got=%0d want=1", accepts - acc0); end
        if (writeSeen != 0)          begin errors++; $display("FAIL busy_write got=%0d want=0", writeSeen); end
        stallsWanted = 0;
    endtask

    task automatic test_back_to_back();
        int base = respCount;
        int acc0 = accepts;
        // Second request held from the RESP cycle; it is taken in the following IDLE cycle.
        push(32'h0, 1'b1, 1);
        push(32'h0, 1'b0, 2);
        issue(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0);
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h9000; req_wdata = 32'h0BADF00D;
        req_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        waitResp(base + 2);
        checks += 2;
        if (accepts - acc0 != 2)     begin errors++; $display("FAIL b2b_accepts got=%0d want=2", accepts - acc0); end
        if (busWd !== 32'h0BADF00D)  begin errors++; $display("FAIL b2b_wdata got=%h want=0BADF00D", busWd); end
    endtask

    task automatic test_reset_mid_bus();
        int base = respCount;
        stuck = 1;
        issue(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0);
        @(negedge clk);
        checks++;
        if (read !== 1'b1)           begin errors++; $display("FAIL mid_read_before got=%b want=1", read); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks += 3;
        if (read !== 1'b0)           begin errors++; $display("FAIL mid_read_after got=%b want=0", read); end
        if (req_ready !== 1'b1)      begin errors++; $display("FAIL mid_ready got=%b want=1", req_ready); end
        if (resp_valid !== 1'b0)     begin errors++; $display("FAIL mid_resp_valid got=%b want=0", resp_valid); end
        stuck = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (respCount != base)       begin errors++; $display("FAIL mid_no_resp got=%0d want=%0d", respCount, base); end
    endtask

`ifdef MIPS_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int base = respCount;
        stuck = 1;
        push(32'h0, 1'b1, 5);
        issue(1'b0, 2'b10, 1'b0, 32'h7000, 32'h0);
        waitResp(base + 1);
        checks++;
        if (busHigh != 4)            begin errors++; $display("FAIL timeout_read_cycles got=%0d want=4", busHigh); end
        stuck = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_bus();
`ifdef MIPS_MEM_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d want=0", sbQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_mem_unit.md
MIPS_CPU_MEM_UNIT -- requirements
Module: mips_cpu_mem_unit

Interface
REQ-001 Parameter WAIT_LIMIT, default 255, SHALL set the maximum waitrequest stall cycles before a timeout error; it is active only with MIPS_MEM_TIMEOUT_EN.
REQ-002 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-003 reset  in  1  SHALL be synchronous and active-high.
REQ-004 req_valid  in  1  core load/store request.
REQ-005 req_ready  out  1  unit idle; request accepted when req_valid&req_ready.
REQ-006 req_write  in  1  1=store, 0=load.
REQ-007 req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 req_signed  in  1  sign-extend load result (LB/LH); ignored for word/stores.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_error  out  1  valid with resp_valid; misaligned/illegal size/timeout.
REQ-014 address, read, write, writedata[31:0], byteenable[3:0]  out; waitrequest, readdata[31:0]  in: Avalon-MM master port.

Function
REQ-015 FSM states SHALL be IDLE, BUS, RDATA, RESP; req_ready=1 only in IDLE.
REQ-016 IDLE: on accept of an aligned, legal request, register all request fields and go to BUS; otherwise stay.
REQ-017 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11 SHALL skip the bus, go to RESP with resp_error=1.
REQ-018 BUS: read or write SHALL be asserted with stable address/byteenable/writedata until a cycle with waitrequest=0.
REQ-019 address SHALL be {addr[31:2],2'b00}; read/write SHALL be 0 outside BUS.
REQ-020 byteenable: byte = 4'b0001<<addr[1:0]; half = addr[1]?4'b1100:4'b0011; word = 4'b1111; lanes little-endian (byte offset 0 = bits 7:0).
REQ-021 writedata SHALL replicate the store byte on all 4 lanes (byte) or the halfword on both halves (half); word unchanged.
REQ-022 Store: BUS with waitrequest=0 SHALL go to RESP; load: go to RDATA.
REQ-023 RDATA: readdata SHALL be sampled (one cycle after read accepted), lane-selected by addr[1:0], zero/sign-extended per req_signed, then go to RESP.
REQ-024 RESP: resp_valid=1 for exactly one cycle, then IDLE; a new request is accepted no earlier than the following cycle.
REQ-025 Best-case latency (waitrequest=0): store accept->resp_valid 2 cycles; load 3 cycles; error 1 cycle.
REQ-026 Requests arriving while req_ready=0 SHALL be ignored (core holds them).

Reset
REQ-027 reset SHALL force IDLE and override any state, including mid-BUS (read/write drop next cycle, no response issued).
REQ-028 Reset values: req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, read=0, write=0, address=0, writedata=0, byteenable=0, stall counter=0.

Configuration
REQ-029 With MIPS_MEM_TIMEOUT_EN defined, a stall counter SHALL count BUS cycles with waitrequest=1; at WAIT_LIMIT it SHALL drop read/write and go to RESP with resp_error=1.
REQ-030 Without MIPS_MEM_TIMEOUT_EN, no counter exists and BUS waits indefinitely.

Structure
REQ-031 Size encodings and FSM state enum SHALL live in shared package mips_cpu_pkg.
REQ-032 Lane select/extension SHALL be a combinational sub-module mips_cpu_load_align.

Verification
REQ-033 LB signed, addr=0x1003, readdata=0x80AABBCC, no wait -> byteenable=1000, resp_rdata=0xFFFFFF80 three cycles after accept.
REQ-034 SH addr=0x2002, wdata=0x0000BEEF, waitrequest high 3 cycles -> write held 4 cycles, byteenable=1100, writedata=0xBEEFBEEF, one resp_valid.
REQ-035 LW addr=0x1001 -> no read asserted, resp_valid+resp_error next cycle, resp_rdata=0.
REQ-036 LHU addr=0x3002, readdata=0x8001FFFF -> resp_rdata=0x00008001.
REQ-037 Reset asserted during BUS with waitrequest=1 -> read=0 next cycle, req_ready=1, no resp_valid.
REQ-038 MIPS_MEM_TIMEOUT_EN, WAIT_LIMIT=4, waitrequest stuck 1 -> read drops after 4 stall cycles, resp_error=1.
